// File: rtl/devil_ar_arbiter.sv
// -----------------------------------------------------------------------------
// devil_ar_arbiter
//   N-engine arbiter for the shared ACE read-address channel (AR/R/RACK).
//   Several requesting engines compete for one read transaction at a time. The
//   grant is held for the whole transaction: AR handshake, every R beat up to
//   RLAST, and the single-cycle RACK. Arbitration is round-robin by default,
//   or lowest-index-wins when FIXED_PRIO=1. Each engine has a saturating count
//   of completed transactions. The block also flags a sticky error when the
//   number of R beats does not match the latched ARLEN.
//
// Ports
//   ace_aclk, ace_aresetn     clock, async active-low reset
//   i_req[N]                  per-engine request level, held until granted
//   i_araddr/i_arsnoop/i_arlen  per-engine AR payload, engine k in slot k
//   o_gnt[N], o_grant_id      one-hot grant and its binary index
//   o_arvalid/i_arready       AR handshake; o_araddr/o_arsnoop/o_arlen latched
//   i_rvalid/i_rready/i_rlast R beat observation (rready comes from the winner)
//   o_rack                    one-cycle RACK after the last beat
//   o_busy                    transaction in flight
//   o_len_err                 sticky beat-count mismatch
//   i_clr                     clears served counters and o_len_err
//   o_served_cnt              per-engine completed transactions, slot k
// -----------------------------------------------------------------------------
module devil_ar_arbiter #(
   parameter int C_ACE_ADDR_WIDTH = 44,
   parameter int NUM_ENGINES      = 4,
   parameter int CNT_WIDTH        = 16,
   parameter int FIXED_PRIO       = 0
) (
   input  logic                             ace_aclk,
   input  logic                             ace_aresetn,
   input  logic [NUM_ENGINES-1:0]           i_req,
   input  logic [NUM_ENGINES*C_ACE_ADDR_WIDTH-1:0] i_araddr,
   input  logic [NUM_ENGINES*4-1:0]         i_arsnoop,
   input  logic [NUM_ENGINES*8-1:0]         i_arlen,
   output logic [NUM_ENGINES-1:0]           o_gnt,
   output logic [2:0]                       o_grant_id,
   output logic                             o_arvalid,
   input  logic                             i_arready,
   output logic [C_ACE_ADDR_WIDTH-1:0]      o_araddr,
   output logic [3:0]                       o_arsnoop,
   output logic [7:0]                       o_arlen,
   input  logic                             i_rvalid,
   input  logic                             i_rready,
   input  logic                             i_rlast,
   output logic                             o_rack,
   output logic                             o_busy,
   output logic                             o_len_err,
   input  logic                             i_clr,
   output logic [NUM_ENGINES*CNT_WIDTH-1:0] o_served_cnt
);

   localparam int AW    = C_ACE_ADDR_WIDTH;
   localparam int IDX_W = 3;
   localparam logic [IDX_W:0]   N_L      = (IDX_W+1)'(NUM_ENGINES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENGINES-1);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ACK} state_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [3:0]    snoop;
      logic [7:0]    len;
   } ar_req_t;

   state_t                      state;
   logic [IDX_W-1:0]            last_ptr;
   logic [8:0]                  beat_cnt;

   ar_req_t [NUM_ENGINES-1:0]   req_pl;
   ar_req_t                     win_pl;
   logic [NUM_ENGINES-1:0]      rot;
   logic [NUM_ENGINES-1:0]      win_oh;
   logic [IDX_W-1:0]            base;
   logic [IDX_W-1:0]            pos;
   logic [IDX_W-1:0]            win_idx;
   logic [IDX_W:0]              sum;
   logic                        win_vld;

   // ---------------------------------------------------------------------------
   // Per-engine payload unpack and one-hot decode of the winner
   // ---------------------------------------------------------------------------
   for (genvar k = 0; k < NUM_ENGINES; k++) begin : g_eng
      assign req_pl[k] = {i_araddr[k*AW +: AW], i_arsnoop[k*4 +: 4], i_arlen[k*8 +: 8]};
      assign win_oh[k] = (win_idx == IDX_W'(k));
   end

   // ---------------------------------------------------------------------------
   // Arbitration: rotate requests so the search start sits at bit 0, take the
   // lowest set bit, then rotate the position back. Fixed priority simply uses
   // a start of 0 so the pointer has no effect.
   // ---------------------------------------------------------------------------
   always_comb begin
      base = '0;
      if (FIXED_PRIO == 0)
         base = (last_ptr == LAST_IDX) ? '0 : last_ptr + IDX_W'(1);
      rot     = NUM_ENGINES'({i_req, i_req} >> base);
      win_vld = |i_req;
      pos     = '0;
      for (int k = NUM_ENGINES-1; k >= 0; k--)
         if (rot[k]) pos = IDX_W'(k);
      sum = {1'b0, base} + {1'b0, pos};
      if (sum >= N_L) sum = sum - N_L;
      win_idx = sum[IDX_W-1:0];
   end

   always_comb begin
      win_pl = '0;
      for (int k = 0; k < NUM_ENGINES; k++)
         if (win_oh[k]) win_pl = req_pl[k];
   end

   // ---------------------------------------------------------------------------
   // Transaction FSM, all outputs registered
   // ---------------------------------------------------------------------------
   always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
      if (!ace_aresetn) begin
         state      <= S_IDLE;
         last_ptr   <= LAST_IDX;
         beat_cnt   <= '0;
         o_gnt      <= '0;
         o_grant_id <= '0;
         o_arvalid  <= 1'b0;
         o_araddr   <= '0;
         o_arsnoop  <= '0;
         o_arlen    <= '0;
         o_rack     <= 1'b0;
         o_busy     <= 1'b0;
         o_len_err  <= 1'b0;
      end else begin
         if (i_clr) o_len_err <= 1'b0;

         case (state)
            S_IDLE: begin
               if (win_vld) begin
                  state      <= S_ADDR;
                  o_gnt      <= win_oh;
                  o_grant_id <= win_idx;
                  o_arvalid  <= 1'b1;
                  o_araddr   <= win_pl.addr;
                  o_arsnoop  <= win_pl.snoop;
                  o_arlen    <= win_pl.len;
                  o_busy     <= 1'b1;
               end
            end

            S_ADDR: begin
               // o_arvalid is always high here, so arready alone completes AR
               if (i_arready) begin
                  o_arvalid <= 1'b0;
                  state     <= S_DATA;
               end
            end

            S_DATA: begin
               if (i_rvalid && i_rready) begin
                  if (i_rlast) begin
                     // beat_cnt holds beats before this one, so a correct burst
                     // ends with beat_cnt == ARLEN
                     if ((beat_cnt != {1'b0, o_arlen}) && !i_clr)
                        o_len_err <= 1'b1;
                     beat_cnt <= '0;
                     o_rack   <= 1'b1;
                     last_ptr <= o_grant_id;
                     state    <= S_ACK;
                  end else if (beat_cnt != '1) begin
                     beat_cnt <= beat_cnt + 9'd1;
                  end
               end
            end

            S_ACK: begin
               o_rack     <= 1'b0;
               o_gnt      <= '0;
               o_grant_id <= '0;
               o_busy     <= 1'b0;
               state      <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Served counters: bump for the granted engine during ACK, saturate,
   // clear has priority over the increment
   // ---------------------------------------------------------------------------
   for (genvar k = 0; k < NUM_ENGINES; k++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_q;

      always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
         if (!ace_aresetn)
            cnt_q <= '0;
         else if (i_clr)
            cnt_q <= '0;
         else if ((state == S_ACK) && o_gnt[k] && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_WIDTH'(1);
      end

      assign o_served_cnt[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
   end

endmodule

// File: tb/tb_devil_ar_arbiter.sv
// -----------------------------------------------------------------------------
// tb_devil_ar_arbiter
//   Directed bench for devil_ar_arbiter. Three instances: default round-robin
//   (0), fixed priority (1), and a 2-bit served counter (2) for saturation.
// -----------------------------------------------------------------------------
module tb_devil_ar_arbiter;

   localparam int AW = 44;

   logic clk = 1'b0;
   logic rst_n;

   logic [3:0]      req      [3];
   logic [4*AW-1:0] araddr_i [3];
   logic [15:0]     arsnoop_i[3];
   logic [31:0]     arlen_i  [3];
   logic            arready  [3];
   logic            rvalid   [3];
   logic            rready   [3];
   logic            rlast    [3];
   logic            clr      [3];

   logic [3:0]      gnt      [3];
   logic [2:0]      gid      [3];
   logic            arvalid  [3];
   logic [AW-1:0]   araddr_o [3];
   logic [3:0]      arsnoop_o[3];
   logic [7:0]      arlen_o  [3];
   logic            rack     [3];
   logic            busy     [3];
   logic            len_err  [3];
   logic [63:0]     served0;
   logic [63:0]     served1;
   logic [7:0]      served2;

   int n_checks = 0;
   int n_errors = 0;
   int id;
   bit rk;

   always #5 clk = ~clk;

   devil_ar_arbiter #(.C_ACE_ADDR_WIDTH(AW), .NUM_ENGINES(4), .CNT_WIDTH(16), .FIXED_PRIO(0)) u_rr (
      .ace_aclk(clk), .ace_aresetn(rst_n), .i_req(req[0]), .i_araddr(araddr_i[0]),
      .i_arsnoop(arsnoop_i[0]), .i_arlen(arlen_i[0]), .o_gnt(gnt[0]), .o_grant_id(gid[0]),
      .o_arvalid(arvalid[0]), .i_arready(arready[0]), .o_araddr(araddr_o[0]),
      .o_arsnoop(arsnoop_o[0]), .o_arlen(arlen_o[0]), .i_rvalid(rvalid[0]), .i_rready(rready[0]),
      .i_rlast(rlast[0]), .o_rack(rack[0]), .o_busy(busy[0]), .o_len_err(len_err[0]),
      .i_clr(clr[0]), .o_served_cnt(served0));

   devil_ar_arbiter #(.C_ACE_ADDR_WIDTH(AW), .NUM_ENGINES(4), .CNT_WIDTH(16), .FIXED_PRIO(1)) u_fp (
      .ace_aclk(clk), .ace_aresetn(rst_n), .i_req(req[1]), .i_araddr(araddr_i[1]),
      .i_arsnoop(arsnoop_i[1]), .i_arlen(arlen_i[1]), .o_gnt(gnt[1]), .o_grant_id(gid[1]),
      .o_arvalid(arvalid[1]), .i_arready(arready[1]), .o_araddr(araddr_o[1]),
      .o_arsnoop(arsnoop_o[1]), .o_arlen(arlen_o[1]), .i_rvalid(rvalid[1]), .i_rready(rready[1]),
      .i_rlast(rlast[1]), .o_rack(rack[1]), .o_busy(busy[1]), .o_len_err(len_err[1]),
      .i_clr(clr[1]), .o_served_cnt(served1));

   devil_ar_arbiter #(.C_ACE_ADDR_WIDTH(AW), .NUM_ENGINES(4), .CNT_WIDTH(2), .FIXED_PRIO(0)) u_sat (
      .ace_aclk(clk), .ace_aresetn(rst_n), .i_req(req[2]), .i_araddr(araddr_i[2]),
      .i_arsnoop(arsnoop_i[2]), .i_arlen(arlen_i[2]), .o_gnt(gnt[2]), .o_grant_id(gid[2]),
      .o_arvalid(arvalid[2]), .i_arready(arready[2]), .o_araddr(araddr_o[2]),
      .o_arsnoop(arsnoop_o[2]), .o_arlen(arlen_o[2]), .i_rvalid(rvalid[2]), .i_rready(rready[2]),
      .i_rlast(rlast[2]), .o_rack(rack[2]), .o_busy(busy[2]), .o_len_err(len_err[2]),
      .i_clr(clr[2]), .o_served_cnt(served2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on instance d; returns granted id and whether RACK
   // was high in the cycle after the last beat.
   task automatic txn(input int d, input logic [3:0] rq, input bit hold, input int nbeats,
                      output int gid_out, output bit rack_out);
      int i;
      req[d] = rq;
      i = 0;
      do begin
         tick();
         i++;
      end while (gnt[d] == 4'b0 && i < 20);
      chk("grant_wait", {63'b0, gnt[d] != 4'b0}, 64'd1);
      gid_out = int'(gid[d]);
      if (!hold) req[d] = 4'b0;
      arready[d] = 1'b1;
      tick();
      arready[d] = 1'b0;
      for (int b = 1; b <= nbeats; b++) begin
         rvalid[d] = 1'b1;
         rready[d] = 1'b1;
         rlast[d]  = (b == nbeats);
         tick();
      end
      rvalid[d] = 1'b0;
      rready[d] = 1'b0;
      rlast[d]  = 1'b0;
      rack_out  = rack[d];
      tick();
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         req[d] = '0; araddr_i[d] = '0; arsnoop_i[d] = '0; arlen_i[d] = '0;
         arready[d] = 0; rvalid[d] = 0; rready[d] = 0; rlast[d] = 0; clr[d] = 0;
      end
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // reset state
      chk("rst_gnt", gnt[0], 0);
      chk("rst_gid", gid[0], 0);
      chk("rst_arvalid", arvalid[0], 0);
      chk("rst_busy", busy[0], 0);
      chk("rst_rack", rack[0], 0);
      chk("rst_len_err", len_err[0], 0);
      chk("rst_araddr", araddr_o[0], 0);
      chk("rst_served", served0, 0);

      // round robin from reset: 0,1,2,3,0,1,2,3
      for (int k = 0; k < 4; k++) begin
         araddr_i[0][k*AW +: AW] = AW'(32'h100 * (k + 1));
         arlen_i[0][k*8 +: 8]    = 8'd0;
      end
      for (int t = 0; t < 8; t++) begin
         txn(0, 4'b1111, 1'b1, 1, id, rk);
         chk($sformatf("rr_id_%0d", t), id, t % 4);
         chk("rr_rack", {63'b0, rk}, 1);
      end
      req[0] = 4'b0;
      chk("rr_served", served0, {16'd2, 16'd2, 16'd2, 16'd2});

      // single transaction with 4 beats; rvalid in IDLE must be ignored first
      araddr_i[0][2*AW +: AW]  = 44'h1000;
      arlen_i[0][2*8 +: 8]     = 8'd3;
      arsnoop_i[0][2*4 +: 4]   = 4'hA;
      rvalid[0] = 1; rready[0] = 1; rlast[0] = 1;
      tick();
      rvalid[0] = 0; rready[0] = 0; rlast[0] = 0;
      chk("idle_r_rack", rack[0], 0);
      chk("idle_r_busy", busy[0], 0);
      req[0] = 4'b0100;
      tick();
      chk("s1_gnt", gnt[0], 4'b0100);
      chk("s1_gid", gid[0], 2);
      chk("s1_arvalid", arvalid[0], 1);
      chk("s1_araddr", araddr_o[0], 44'h1000);
      chk("s1_arlen", arlen_o[0], 3);
      chk("s1_arsnoop", arsnoop_o[0], 4'hA);
      chk("s1_busy", busy[0], 1);
      req[0] = 4'b0;
      arready[0] = 1;
      tick();
      arready[0] = 0;
      chk("s1_arvalid_drop", arvalid[0], 0);
      for (int b = 1; b <= 4; b++) begin
         rvalid[0] = 1; rready[0] = 1; rlast[0] = (b == 4);
         tick();
         chk($sformatf("s1_rack_b%0d", b), rack[0], (b == 4));
      end
      rvalid[0] = 0; rready[0] = 0; rlast[0] = 0;
      chk("s1_len_err", len_err[0], 0);
      chk("s1_gnt_ack", gnt[0], 4'b0100);
      tick();
      chk("s1_rack_end", rack[0], 0);
      chk("s1_gnt_end", gnt[0], 0);
      chk("s1_busy_end", busy[0], 0);
      chk("s1_served2", served0[47:32], 3);

      // AR stall: payload stable, R beats and other requests ignored
      araddr_i[0][1*AW +: AW] = 44'hABC_DEF0_1234;
      arlen_i[0][1*8 +: 8]    = 8'd0;
      req[0] = 4'b0010;
      tick();
      chk("st_arvalid0", arvalid[0], 1);
      req[0] = 4'b0;
      for (int s = 1; s <= 5; s++) begin
         rvalid[0] = 1; rready[0] = 1; rlast[0] = 1;
         req[0] = 4'b1000;
         araddr_i[0][3*AW +: AW] = 44'hFFF_FFFF_FFFF;
         tick();
         chk($sformatf("st_arvalid%0d", s), arvalid[0], 1);
         chk($sformatf("st_araddr%0d", s), araddr_o[0], 44'hABC_DEF0_1234);
         chk($sformatf("st_rack%0d", s), rack[0], 0);
      end
      rvalid[0] = 0; rready[0] = 0; rlast[0] = 0; req[0] = 4'b0;
      arready[0] = 1;
      tick();
      arready[0] = 0;
      chk("st_arvalid_drop", arvalid[0], 0);
      rvalid[0] = 1; rready[0] = 1; rlast[0] = 1;
      tick();
      rvalid[0] = 0; rready[0] = 0; rlast[0] = 0;
      chk("st_rack", rack[0], 1);
      chk("st_len_err", len_err[0], 0);
      tick();
      chk("st_served", served0, {16'd2, 16'd3, 16'd3, 16'd2});

      // length error: arlen 3, last on beat 2
      araddr_i[0][0 +: AW] = 44'h5000;
      arlen_i[0][0 +: 8]   = 8'd3;
      txn(0, 4'b0001, 1'b0, 2, id, rk);
      chk("le_id", id, 0);
      chk("le_rack", {63'b0, rk}, 1);
      chk("le_err", len_err[0], 1);
      txn(0, 4'b0001, 1'b0, 4, id, rk);
      chk("le_sticky", len_err[0], 1);
      chk("le_served0", served0[15:0], 4);
      clr[0] = 1;
      tick();
      clr[0] = 0;
      chk("clr_err", len_err[0], 0);
      chk("clr_served", served0, 0);

      // clear in the same cycle as a length error and as the increment
      req[0] = 4'b0001;
      tick();
      req[0] = 4'b0;
      arready[0] = 1;
      tick();
      arready[0] = 0;
      rvalid[0] = 1; rready[0] = 1;
      tick();
      rlast[0] = 1; clr[0] = 1;
      tick();
      rvalid[0] = 0; rready[0] = 0; rlast[0] = 0;
      chk("cw_rack", rack[0], 1);
      chk("cw_err", len_err[0], 0);
      tick();
      clr[0] = 0;
      chk("cw_served", served0, 0);

      // fixed priority: engine 1 wins repeatedly over engine 3
      for (int t = 0; t < 3; t++) begin
         txn(1, 4'b1010, 1'b1, 1, id, rk);
         chk($sformatf("fp_id_%0d", t), id, 1);
      end
      req[1] = 4'b0;
      chk("fp_cnt1", served1[31:16], 3);
      chk("fp_cnt3", served1[63:48], 0);

      // saturation with 2-bit counters
      for (int t = 0; t < 5; t++) txn(2, 4'b0001, 1'b0, 1, id, rk);
      chk("sat_cnt", served2, 8'h03);

      // async reset in DATA after two beats
      araddr_i[0][2*AW +: AW] = 44'h6000;
      req[0] = 4'b0100;
      tick();
      req[0] = 4'b0;
      arready[0] = 1;
      tick();
      arready[0] = 0;
      rvalid[0] = 1; rready[0] = 1;
      repeat (2) tick();
      rvalid[0] = 0; rready[0] = 0;
      #1 rst_n = 1'b0;
      #1;
      chk("ar_gnt", gnt[0], 0);
      chk("ar_gid", gid[0], 0);
      chk("ar_arvalid", arvalid[0], 0);
      chk("ar_busy", busy[0], 0);
      chk("ar_rack", rack[0], 0);
      chk("ar_araddr", araddr_o[0], 0);
      chk("ar_arlen", arlen_o[0], 0);
      #1 rst_n = 1'b1;
      req[0] = 4'b0101;
      tick();
      chk("ar_regnt", gnt[0], 4'b0001);
      chk("ar_regid", gid[0], 0);
      chk("ar_readdr", araddr_o[0], 44'h5000);
      req[0] = 4'b0;
      arready[0] = 1;
      tick();
      arready[0] = 0;
      for (int b = 1; b <= 4; b++) begin
         rvalid[0] = 1; rready[0] = 1; rlast[0] = (b == 4);
         tick();
      end
      rvalid[0] = 0; rready[0] = 0; rlast[0] = 0;
      chk("ar_rerack", rack[0], 1);
      chk("ar_relen", len_err[0], 0);
      tick();
      chk("ar_served", served0, 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
